pf_clk_div_delay_ctrl: RTL

Multi-channel tap controller for the clock-divider delay lines in the IOD clocking path. Accepts step/load commands on a valid/ready interface, sequences the per-channel DELAY_LINE_DIR/MOVE/LOAD strobes with a programmable settle gap, and tracks each channel's current tap. It also saturates at the tap limits and aborts on the primitive's out-of-range flag. It sits between the bit-clock alignment logic and up to four clock-divider-delay instances.

---
 rtl/pf_clk_div_delay_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pf_clk_div_delay_ctrl.sv
// Tap controller for up to four clock-divider delay lines: sequences DIR/MOVE/LOAD
// strobes with a settle gap, tracks each channel's tap and saturates at the limits.
module pf_clk_div_delay_ctrl #(
    parameter int NUM_CH   = 1,
    parameter int TAP_W    = 8,
    parameter int MAX_TAP  = 255,
    parameter int INIT_TAP = 1,
    parameter int MOVE_GAP = 2
) (
    input  logic                     SCLK,
    input  logic                     RESETN,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_CH,
    input  logic [1:0]               CMD_OP,
    input  logic [TAP_W-1:0]         CMD_COUNT,
    output logic                     DONE,
    output logic                     ERR,
    output logic [NUM_CH*TAP_W-1:0]  TAP_CNT,
    output logic [NUM_CH-1:0]        DELAY_LINE_DIR,
    output logic [NUM_CH-1:0]        DELAY_LINE_MOVE,
    output logic [NUM_CH-1:0]        DELAY_LINE_LOAD,
    input  logic [NUM_CH-1:0]        DELAY_LINE_OUT_OF_RANGE
);

    localparam int              GAP_W     = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MOVE_GAP - 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
    localparam logic [2:0]       CH_LIMIT = 3'(NUM_CH);

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_LOAD,
        S_FIN
    } state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      ch_q, ch_d;
    logic                            inc_q, inc_d;
    logic [TAP_W-1:0]                cnt_q, cnt_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            err_q, err_d;
    logic [NUM_CH-1:0][TAP_W-1:0]    tap_q, tap_d;
    logic [NUM_CH-1:0]               dir_q, dir_d;
    logic [NUM_CH-1:0]               move_q, move_d;
    logic [NUM_CH-1:0]               load_q, load_d;
    logic                            ready_q, ready_d;
    logic                            done_q, done_d;
    logic                            err_out_q, err_out_d;

    logic [TAP_W-1:0]                cur_tap;
    logic                            cur_oor;
    logic                            at_limit;
    logic [NUM_CH-1:0]               ch_sel;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ch_d      = ch_q;
        inc_d     = inc_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        err_d     = err_q;
        tap_d     = tap_q;
        dir_d     = dir_q;
        cur_tap   = '0;
        cur_oor   = 1'b0;
        ch_sel    = '0;

        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_q == 2'(n)) begin
                cur_tap = tap_q[n];
                cur_oor = DELAY_LINE_OUT_OF_RANGE[n];
            end
        end
        // Limit test for the step that would come next, in the latched direction.
        at_limit = inc_q ? (cur_tap == TAP_MAX) : (cur_tap == '0);

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    ch_d  = CMD_CH;
                    inc_d = (CMD_OP == OP_INC);
                    cnt_d = CMD_COUNT;
                    err_d = 1'b0;
                    if (CMD_OP == OP_ILL || {1'b0, CMD_CH} >= CH_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (CMD_OP == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (CMD_COUNT == '0) begin
                        state_d = S_FIN;
                    end else begin
                        // DIR is set on entry so it is already valid during SETUP.
                        for (int n = 0; n < NUM_CH; n++) begin
                            if (CMD_CH == 2'(n)) dir_d[n] = (CMD_OP == OP_INC);
                        end
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (at_limit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_q == 2'(n)) begin
                        tap_d[n] = inc_q ? tap_q[n] + TAP_W'(1) : tap_q[n] - TAP_W'(1);
                    end
                end
                cnt_d   = cnt_q - TAP_W'(1);
                gap_d   = GAP_LAST;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (cur_oor) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else if (at_limit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_LOAD: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_q == 2'(n)) tap_d[n] = TAP_INIT;
                end
                cnt_d   = '0;
                gap_d   = GAP_LAST;
                state_d = S_GAP;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int n = 0; n < NUM_CH; n++) begin
            ch_sel[n] = (ch_d == 2'(n));
        end
        // Outputs are decoded from the next state so the registered strobes line up with it.
        ready_d   = (state_d == S_IDLE);
        done_d    = (state_d == S_FIN);
        err_out_d = (state_d == S_FIN) && err_d;
        move_d    = (state_d == S_MOVE) ? ch_sel : '0;
        load_d    = (state_d == S_LOAD) ? ch_sel : '0;
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            inc_q     <= 1'b0;
            cnt_q     <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            tap_q     <= {NUM_CH{TAP_INIT}};
            dir_q     <= '0;
            move_q    <= '0;
            load_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            ch_q      <= ch_d;
            inc_q     <= inc_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            tap_q     <= tap_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
            load_q    <= load_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
        end
    end

    assign CMD_READY       = ready_q;
    assign DONE            = done_q;
    assign ERR             = err_out_q;
    assign TAP_CNT         = tap_q;
    assign DELAY_LINE_DIR  = dir_q;
    assign DELAY_LINE_MOVE = move_q;
    assign DELAY_LINE_LOAD = load_q;

endmodule
